// File: rtl/alu_arb_pkg.sv
// Shared opcodes, FSM encoding and flag layout for alu_arbiter.
// op_legal() is consulted only when ALU_ARB_OPCHK_EN is defined.
package alu_arb_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_RES   = 3'd2,
    ST_FLG   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam int FLG_ZF = 3;
  localparam int FLG_CF = 2;
  localparam int FLG_OF = 1;
  localparam int FLG_SF = 0;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_SUB) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past i_ptr and wraps.
// Grants nothing while i_adv is low.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_adv,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % NREQ);
      if (i_adv && !w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU: one op in flight, response after 4 cycles.
// Build with ALU_ARB_OPCHK_EN to reject illegal opcodes with rsp_err in 1 cycle.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [3:0]        alu_op,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_zf,
  input  logic              alu_cf,
  input  logic              alu_of,
  input  logic              alu_sf
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_tag;
  logic [W-1:0]    r_alu_a;
  logic [W-1:0]    r_alu_b;
  logic [3:0]      r_alu_op;
  logic [NREQ-1:0] r_rsp_valid;
  logic [W-1:0]    r_rsp_data;
  logic [3:0]      r_rsp_flags;
`ifdef ALU_ARB_OPCHK_EN
  logic            r_rsp_err;
`endif

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_adv;
  logic            w_req_hs;
  logic            w_rsp_hs;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [3:0]      w_op;
  logic [NREQ-1:0] w_tag_oh;

  // Arbitration is only live in IDLE, and never while reset is asserted.
  assign w_adv = (r_state == ST_IDLE) && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_adv   (w_adv),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign req_ready = w_grant;
  assign w_req_hs  = |(req_valid & w_grant);
  assign w_rsp_hs  = |(r_rsp_valid & rsp_ready);
  assign w_tag_oh  = {{(NREQ-1){1'b0}}, 1'b1} << r_tag;

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_a  = req_a[i*W +: W];
        w_b  = req_b[i*W +: W];
        w_op = req_op[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= IW'(NREQ - 1);
      r_tag       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
`ifdef ALU_ARB_OPCHK_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_hs) begin
            r_tag <= w_idx;
            r_ptr <= w_idx;
`ifdef ALU_ARB_OPCHK_EN
            // Rejected ops leave the ALU operands untouched and answer at once.
            if (!op_legal(w_op)) begin
              r_rsp_data  <= '0;
              r_rsp_flags <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= w_grant;
              r_state     <= ST_RESP;
            end else
`endif
            begin
              r_alu_a  <= w_a;
              r_alu_b  <= w_b;
              r_alu_op <= w_op;
              r_state  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: r_state <= ST_RES;
        ST_RES: begin
          r_rsp_data <= alu_out;
          r_state    <= ST_FLG;
        end
        ST_FLG: begin
          // Flags trail the result by one cycle in the ALU pipeline.
          r_rsp_flags[FLG_ZF] <= alu_zf;
          r_rsp_flags[FLG_CF] <= alu_cf;
          r_rsp_flags[FLG_OF] <= alu_of;
          r_rsp_flags[FLG_SF] <= alu_sf;
`ifdef ALU_ARB_OPCHK_EN
          r_rsp_err           <= 1'b0;
`endif
          r_rsp_valid         <= w_tag_oh;
          r_state             <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_flags = r_rsp_flags;
`ifdef ALU_ARB_OPCHK_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin controller that shares the single registered ALU among NREQ requesters. It accepts one operation at a time over a per-requester valid/ready request channel, drives and holds the ALU operands, and captures the result and the later-arriving flags. It returns both to the originating requester over a valid/ready response channel. It sits between the issue logic of the execution units and the ALU instance.

## Interface
- NREQ, 4: number of requesters (2..8).
- W, 32: operand/result width; fixed to match the ALU.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted; at most one bit high.
- req_a  in  NREQ*W  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*W  packed operand B.
- req_op  in  NREQ*4  packed ALU opcode.
- rsp_valid  out  NREQ  response valid, one-hot.
- rsp_ready  in  NREQ  response accepted.
- rsp_data  out  W  result, shared by all requesters.
- rsp_flags  out  4  {ZF,CF,OF,SF}.
- rsp_err  out  1  illegal opcode; tied 0 when the check is compiled out.
- alu_a, alu_b  out  W  ALU operands, registered.
- alu_op  out  4  ALU opcode, registered.
- alu_out  in  W  ALU result.
- alu_zf, alu_cf, alu_of, alu_sf  in  1  ALU flags.

## Operation
- FSM states:
  - IDLE -> ISSUE on request handshake.
  - ISSUE -> RES -> FLG -> RESP, unconditional.
  - RESP -> IDLE on `rsp_valid[g] & rsp_ready[g]`.
- Arbitration in IDLE only, combinational:
  - Priority starts at `ptr+1` and wraps modulo NREQ.
  - Winner g gets `req_ready[g]=1`. Handshake is `req_valid[g]&req_ready[g]`.
  - `ptr<=g` on handshake.
- `req_ready` is all 0 outside IDLE and while rst is high.
- On handshake: `alu_a/alu_b/alu_op` load slice g; g is stored as the tag.
- `alu_*` hold their value in every state until the next handshake. The ALU has no enable, so the operands must stay stable through FLG.
- RES: `rsp_data<=alu_out`.
- FLG: `rsp_flags<={alu_zf,alu_cf,alu_of,alu_sf}`.
- RESP: `rsp_valid[g]=1`, with `rsp_data/rsp_flags/rsp_err` stable until the handshake.
- No new request is accepted before the response handshake; one operation is in flight at most.
- A requester keeping `req_valid` high after a handshake is a new request.
- Reset values:
  - state=IDLE, ptr=NREQ-1 (requester 0 wins first).
  - `alu_a=alu_b=0`, `alu_op=0`.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_flags=0`, `rsp_err=0`, tag=0.
- Reset mid-operation: the in-flight operation is dropped silently, no response is produced, and ptr returns to NREQ-1.

## Timing
- Request handshake in cycle A.
- Cycle A+1: ISSUE, `alu_*` valid; the ALU registers them at the end of A+1.
- Cycle A+2: RES, `alu_out` valid and sampled at the end of A+2.
- Cycle A+3: FLG, flags valid (they lag the result by one cycle) and sampled at the end of A+3.
- Cycle A+4: RESP, `rsp_valid` high. Minimum latency is 4 cycles.
- Response handshake in cycle R. IDLE is in R+1, and the earliest next request handshake is R+1.
- Peak throughput: one operation per 5 cycles.
- `rsp_ready` held low keeps RESP indefinitely with the outputs unchanged.

## Configuration
- `ALU_ARB_OPCHK_EN` defined:
  - Legal opcodes are 0000–1000 and 1101.
  - An illegal opcode is still handshaken and the tag is recorded.
  - `alu_*` are not reloaded and the FSM goes IDLE -> RESP directly; `rsp_valid` is high in A+1.
  - Response is `rsp_data=0`, `rsp_flags=0`, `rsp_err=1`. ptr updates normally.
  - Legal operations give `rsp_err=0`.
- `ALU_ARB_OPCHK_EN` undefined:
  - Every opcode follows the normal path.
  - The response is whatever the ALU presents.
  - `rsp_err` is constant 0.

## Structure
- Package `alu_arb_pkg` holds:
  - Opcode localparams (ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101).
  - FSM state encoding.
  - Flag bit indices (ZF=3, CF=2, OF=1, SF=0).
  - The legal-opcode function.
- Sub-module `rr_arbiter`, parameterised by NREQ: inputs are the request vector, ptr and advance; outputs are the one-hot grant and the index.

## Test plan
- Requester 0 only, `a=5`, `b=3`, op=0000 -> response to requester 0 at A+4 with `rsp_data=8`, `rsp_flags=4'b0000`.
- Requester 2, `a=5`, `b=5`, op=1000 -> `rsp_data=0`, `rsp_flags=4'b1000`.
- All four requesting continuously after reset, `rsp_ready` always 1 -> grant order 0,1,2,3,0, with 5 cycles between handshakes.
- `rsp_ready` held low for 10 cycles in RESP -> `rsp_valid`, data and flags stable, `req_ready` all 0, no ALU operand change.
- rst pulsed during RES of an operation from requester 1 -> no response is ever issued; with all requesting, the next grant goes to requester 0.
- With `ALU_ARB_OPCHK_EN`, op=1111 -> `rsp_valid` at A+1, `rsp_err=1`, `rsp_data=0`, `alu_op` unchanged. Without the macro, the same stimulus gives `rsp_err=0` and latency 4.
